// File: rtl/tl_width_adapter_if.sv
// TileLink-UL/UH A and D channel bundle for one port of a given data width.
// The adapter's upstream side uses the slave modport and its downstream side
// the master modport.
interface tl_width_adapter_if #(
    parameter int BYTES    = 16,
    parameter int ADDR_W   = 29,
    parameter int SOURCE_W = 6
);
    // A channel: request, master to slave
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_bits_opcode;
    logic [2:0]          a_bits_param;
    logic [3:0]          a_bits_size;
    logic [SOURCE_W-1:0] a_bits_source;
    logic [ADDR_W-1:0]   a_bits_address;
    logic [BYTES-1:0]    a_bits_mask;
    logic [8*BYTES-1:0]  a_bits_data;
    logic                a_bits_corrupt;

    // D channel: response, slave to master
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_bits_opcode;
    logic [1:0]          d_bits_param;
    logic [3:0]          d_bits_size;
    logic [SOURCE_W-1:0] d_bits_source;
    logic                d_bits_sink;
    logic                d_bits_denied;
    logic [8*BYTES-1:0]  d_bits_data;
    logic                d_bits_corrupt;

    modport master (
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        input  a_ready,
        input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        output a_ready,
        output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_width_adapter.sv
// TileLink-UL/UH width adapter: wide upstream port (IN_BYTES) to narrow
// downstream port (OUT_BYTES).
//  - A: each wide beat is split into narrow beats by a lane counter.
//    There is no buffering, so the wide beat is held upstream until its
//    last narrow beat is accepted.
//  - D: narrow data beats are gathered into one wide beat in a holding
//    register. The wide beat is presented together with the final narrow beat.
// Optional macro TL_WIDTH_ADAPTER_DREG_EN inserts a 2-entry skid register on
// the upstream D output. This breaks the in_d_ready -> out_d_ready path at the
// cost of one cycle of latency.
module tl_width_adapter #(
    parameter int IN_BYTES  = 16,
    parameter int OUT_BYTES = 8,
    parameter int ADDR_W    = 29,
    parameter int SOURCE_W  = 6
) (
    input  logic               clock,
    input  logic               reset,
    tl_width_adapter_if.slave  auto_in,
    tl_width_adapter_if.master auto_out
);
    localparam int RATIO = IN_BYTES / OUT_BYTES;
    localparam int LG    = $clog2(OUT_BYTES);
    localparam int LG_R  = $clog2(RATIO);
    localparam int CW    = (LG_R > 0) ? LG_R : 1;
    localparam int NB    = 8 * OUT_BYTES;
    localparam int BUF_N = (RATIO > 1) ? RATIO - 1 : 1;

    typedef logic [CW-1:0] idx_t;

    // One wide D beat as presented upstream.
    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [3:0]          size;
        logic [SOURCE_W-1:0] source;
        logic                sink;
        logic                denied;
        logic [8*IN_BYTES-1:0] data;
        logic                corrupt;
    } d_beat_t;

    // Index of the last narrow beat of a multi-beat group of 2^size bytes.
    // The group length is capped at RATIO narrow beats.
    function automatic idx_t group_last(input logic [3:0] size);
        int excess;
        if (int'(size) <= LG) return '0;
        excess = int'(size) - LG;
        if (excess >= LG_R) return idx_t'(RATIO - 1);
        return idx_t'((1 << excess) - 1);
    endfunction

    // ------------------------------------------------------------------
    // A channel split
    // ------------------------------------------------------------------
    idx_t r_a_idx;
    idx_t w_a_last_idx;
    idx_t w_a_lane;
    logic w_a_last;
    logic w_a_valid;
    logic w_a_fire;

    // Number of narrow beats this wide request needs.
    // Only Put/Arithmetic/Logical requests (opcodes 0-3) carry data and split.
    // Get and Intent requests (opcodes 4-5) always take a single beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_a_last_idx = '0;
        if (auto_in.a_bits_opcode <= 3'd3)
            w_a_last_idx = group_last(auto_in.a_bits_size);
    end

    assign w_a_last  = (r_a_idx == w_a_last_idx);
    assign w_a_lane  = (idx_t'(auto_in.a_bits_address >> LG) + r_a_idx) & idx_t'(RATIO - 1);
    assign w_a_valid = auto_in.a_valid & ~reset;
    assign w_a_fire  = w_a_valid & auto_out.a_ready;

    assign auto_out.a_valid          = w_a_valid;
    assign auto_out.a_bits_opcode    = auto_in.a_bits_opcode;
    assign auto_out.a_bits_param     = auto_in.a_bits_param;
    assign auto_out.a_bits_size      = auto_in.a_bits_size;
    assign auto_out.a_bits_source    = auto_in.a_bits_source;
    assign auto_out.a_bits_address   = auto_in.a_bits_address;
    assign auto_out.a_bits_corrupt   = auto_in.a_bits_corrupt;
    assign auto_out.a_bits_data      = auto_in.a_bits_data[w_a_lane*NB +: NB];
    assign auto_out.a_bits_mask      = auto_in.a_bits_mask[w_a_lane*OUT_BYTES +: OUT_BYTES];
    assign auto_in.a_ready           = auto_out.a_ready & w_a_last & ~reset;

    // Advance the split lane on each accepted narrow beat and wrap after the last one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state is only ever assigned with <= so all flops update together.
            r_a_idx <= '0;
        end else if (w_a_fire) begin
            r_a_idx <= w_a_last ? '0 : r_a_idx + idx_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // D channel gather
    // ------------------------------------------------------------------
    idx_t          r_d_idx;
    logic [NB-1:0] r_buf [BUF_N];
    logic          r_denied_acc;
    logic          r_corrupt_acc;

    logic                  w_d_is_data;
    idx_t                  w_d_last_idx;
    logic                  w_d_last;
    logic                  w_d_ready;
    logic                  w_d_fire;
    logic                  w_up_valid;
    logic                  w_up_ready;
    logic [8*IN_BYTES-1:0] w_d_data;
    d_beat_t               w_d_beat;
    d_beat_t               w_d_out;

    // Work out the gather group length. Only AccessAckData (opcode 1) and
    // GrantData (opcode 5) carry data, and only those with size > LG need
    // more than one narrow beat.
    always_comb begin
        w_d_is_data  = (auto_out.d_bits_opcode == 3'd1) || (auto_out.d_bits_opcode == 3'd5);
        w_d_last_idx = '0;
        if (w_d_is_data)
            w_d_last_idx = group_last(auto_out.d_bits_size);
    end

    assign w_d_last = (r_d_idx == w_d_last_idx);

    // Assemble the wide beat. Lane i takes group slot (i mod group).
    // That slot is either the current narrow beat or a stored one.
    // This also replicates short groups across the remaining lanes.
    always_comb begin
        w_d_data = '0;
        if (w_d_is_data) begin
            for (int i = 0; i < RATIO; i++) begin
                if ((idx_t'(i) & w_d_last_idx) == r_d_idx) begin
                    w_d_data[i*NB +: NB] = auto_out.d_bits_data;
                end else begin
                    for (int k = 0; k < BUF_N; k++) begin
                        if (idx_t'(k) == (idx_t'(i) & w_d_last_idx))
                            w_d_data[i*NB +: NB] = r_buf[k];
                    end
                end
            end
        end
    end

    assign w_d_beat.opcode  = auto_out.d_bits_opcode;
    assign w_d_beat.param   = auto_out.d_bits_param;
    assign w_d_beat.size    = auto_out.d_bits_size;
    assign w_d_beat.source  = auto_out.d_bits_source;
    assign w_d_beat.sink    = auto_out.d_bits_sink;
    assign w_d_beat.denied  = r_denied_acc | auto_out.d_bits_denied;
    assign w_d_beat.corrupt = r_corrupt_acc | auto_out.d_bits_corrupt;
    assign w_d_beat.data    = w_d_data;

    // Non-final beats are always absorbed.
    // The final beat waits on the upstream side.
    assign w_up_valid       = auto_out.d_valid & w_d_last & ~reset;
    assign w_d_ready        = ~reset & (~w_d_last | w_up_ready);
    assign w_d_fire         = auto_out.d_valid & w_d_ready;
    assign auto_out.d_ready = w_d_ready;

    // Store non-final narrow beats and OR-accumulate their error flags.
    // The accepted final beat clears the group.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_d_idx       <= '0;
            r_denied_acc  <= 1'b0;
            r_corrupt_acc <= 1'b0;
            // NOTE: the gather buffer is reset so a group discarded by reset can never leak into a later beat.
            for (int k = 0; k < BUF_N; k++)
                r_buf[k] <= '0;
        end else if (w_d_fire) begin
            if (w_d_last) begin
                r_d_idx       <= '0;
                r_denied_acc  <= 1'b0;
                r_corrupt_acc <= 1'b0;
            end else begin
                r_d_idx       <= r_d_idx + idx_t'(1);
                r_denied_acc  <= r_denied_acc | auto_out.d_bits_denied;
                r_corrupt_acc <= r_corrupt_acc | auto_out.d_bits_corrupt;
                for (int k = 0; k < BUF_N; k++) begin
                    if (idx_t'(k) == r_d_idx)
                        r_buf[k] <= auto_out.d_bits_data;
                end
            end
        end
    end

`ifdef TL_WIDTH_ADAPTER_DREG_EN
    // Two-entry skid register on the upstream D output.
    // Readiness depends only on occupancy, never on in_d_ready.
    d_beat_t    r_skid [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign w_up_ready = (r_count != 2'd2);
    assign w_push     = w_up_valid & w_up_ready;
    assign w_pop      = (r_count != 2'd0) & auto_in.d_ready;

    // Skid pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Skid storage. It is qualified by the occupancy count, so it needs no reset.
    always_ff @(posedge clock) begin
        if (w_push) r_skid[r_wr_ptr] <= w_d_beat;
    end

    assign w_d_out         = r_skid[r_rd_ptr];
    assign auto_in.d_valid = (r_count != 2'd0) & ~reset;
`else
    assign w_up_ready      = auto_in.d_ready;
    assign w_d_out         = w_d_beat;
    assign auto_in.d_valid = w_up_valid;
`endif

    assign auto_in.d_bits_opcode  = w_d_out.opcode;
    assign auto_in.d_bits_param   = w_d_out.param;
    assign auto_in.d_bits_size    = w_d_out.size;
    assign auto_in.d_bits_source  = w_d_out.source;
    assign auto_in.d_bits_sink    = w_d_out.sink;
    assign auto_in.d_bits_denied  = w_d_out.denied;
    assign auto_in.d_bits_data    = w_d_out.data;
    assign auto_in.d_bits_corrupt = w_d_out.corrupt;

endmodule

// File: tb/tb_tl_width_adapter.sv
// Directed bench for tl_width_adapter (IN=16, OUT=8, default build).
// A channel: table of per-cycle vectors.
// D channel: hand-written gather, stall and reset sequences.
module tb_tl_width_adapter;
    localparam int IN_BYTES  = 16;
    localparam int OUT_BYTES = 8;
    localparam int ADDR_W    = 29;
    localparam int SOURCE_W  = 6;

    localparam logic [63:0]  L5    = 64'h5555_5555_5555_5555;
    localparam logic [63:0]  LA    = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0]  LO2   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0]  HI2   = 64'h0123_4567_89AB_CDEF;
    localparam logic [127:0] D_PUT = {LA, L5};
    localparam logic [127:0] D_TWO = {HI2, LO2};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    tl_width_adapter_if #(.BYTES(IN_BYTES),  .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)) auto_in ();
    tl_width_adapter_if #(.BYTES(OUT_BYTES), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W)) auto_out ();

    tl_width_adapter #(
        .IN_BYTES (IN_BYTES),
        .OUT_BYTES(OUT_BYTES),
        .ADDR_W   (ADDR_W),
        .SOURCE_W (SOURCE_W)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .auto_in (auto_in),
        .auto_out(auto_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_d(input logic [2:0] op, input logic [3:0] sz, input logic [63:0] data,
                         input logic denied, input logic corrupt);
        auto_out.d_valid        = 1'b1;
        auto_out.d_bits_opcode  = op;
        auto_out.d_bits_param   = 2'd0;
        auto_out.d_bits_size    = sz;
        auto_out.d_bits_source  = 6'h2A;
        auto_out.d_bits_sink    = 1'b0;
        auto_out.d_bits_denied  = denied;
        auto_out.d_bits_data    = data;
        auto_out.d_bits_corrupt = corrupt;
    endtask

    // One A-channel cycle: inputs and the expected narrow beat.
    typedef struct {
        logic              v;
        logic [2:0]        op;
        logic [3:0]        sz;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       mask;
        logic [127:0]      data;
        logic              ordy;
        logic              e_ov;
        logic [7:0]        e_mask;
        logic [63:0]       e_data;
        logic              e_irdy;
    } a_vec_t;

    a_vec_t vecs [12];

    initial begin
        // Fields: v, op, sz, addr, mask, data, out_a_ready |
        //         out_a_valid, out_mask, out_data, in_a_ready
        vecs[0]  = '{1'b1, 3'd0, 4'd4, 29'h100, 16'hFFFF, D_PUT, 1'b1, 1'b1, 8'hFF, L5,  1'b0};
        vecs[1]  = '{1'b1, 3'd0, 4'd4, 29'h100, 16'hFFFF, D_PUT, 1'b1, 1'b1, 8'hFF, LA,  1'b1};
        vecs[2]  = '{1'b1, 3'd4, 4'd2, 29'h10C, 16'hF000, D_PUT, 1'b1, 1'b1, 8'hF0, LA,  1'b1};
        vecs[3]  = '{1'b1, 3'd0, 4'd4, 29'h200, 16'hFFFF, D_TWO, 1'b0, 1'b1, 8'hFF, LO2, 1'b0};
        vecs[4]  = '{1'b1, 3'd0, 4'd4, 29'h200, 16'hFFFF, D_TWO, 1'b1, 1'b1, 8'hFF, LO2, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 4'd4, 29'h200, 16'hFFFF, D_TWO, 1'b0, 1'b1, 8'hFF, HI2, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 4'd4, 29'h200, 16'hFFFF, D_TWO, 1'b1, 1'b1, 8'hFF, HI2, 1'b1};
        vecs[7]  = '{1'b1, 3'd1, 4'd3, 29'h108, 16'hFF00, D_TWO, 1'b1, 1'b1, 8'hFF, HI2, 1'b1};
        vecs[8]  = '{1'b1, 3'd4, 4'd4, 29'h100, 16'hFFFF, D_TWO, 1'b1, 1'b1, 8'hFF, LO2, 1'b1};
        vecs[9]  = '{1'b1, 3'd0, 4'd5, 29'h000, 16'hFFFF, D_PUT, 1'b1, 1'b1, 8'hFF, L5,  1'b0};
        vecs[10] = '{1'b1, 3'd0, 4'd5, 29'h000, 16'hFFFF, D_PUT, 1'b1, 1'b1, 8'hFF, LA,  1'b1};
        vecs[11] = '{1'b0, 3'd4, 4'd2, 29'h000, 16'h0000, D_PUT, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1};

        // Reset with live handshakes on both sides: all valid/ready outputs must stay low.
        reset                   = 1'b1;
        auto_in.a_valid         = 1'b1;
        auto_in.a_bits_opcode   = 3'd4;
        auto_in.a_bits_param    = 3'd0;
        auto_in.a_bits_size     = 4'd2;
        auto_in.a_bits_source   = '0;
        auto_in.a_bits_address  = '0;
        auto_in.a_bits_mask     = '0;
        auto_in.a_bits_data     = '0;
        auto_in.a_bits_corrupt  = 1'b0;
        auto_in.d_ready         = 1'b1;
        auto_out.a_ready        = 1'b1;
        set_d(3'd1, 4'd2, 64'h0, 1'b0, 1'b0);
        #12;
        check("rst_out_a_valid", 128'(auto_out.a_valid), 128'(1'b0));
        check("rst_in_a_ready",  128'(auto_in.a_ready),  128'(1'b0));
        check("rst_out_d_ready", 128'(auto_out.d_ready), 128'(1'b0));
        check("rst_in_d_valid",  128'(auto_in.d_valid),  128'(1'b0));
        auto_in.a_valid  = 1'b0;
        auto_out.d_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();

        // A-channel vectors, one cycle each.
        for (int i = 0; i < 12; i++) begin
            auto_in.a_valid        = vecs[i].v;
            auto_in.a_bits_opcode  = vecs[i].op;
            auto_in.a_bits_size    = vecs[i].sz;
            auto_in.a_bits_address = vecs[i].addr;
            auto_in.a_bits_mask    = vecs[i].mask;
            auto_in.a_bits_data    = vecs[i].data;
            auto_in.a_bits_source  = 6'(i);
            auto_out.a_ready       = vecs[i].ordy;
            #3;
            check($sformatf("a%0d_out_valid", i), 128'(auto_out.a_valid), 128'(vecs[i].e_ov));
            check($sformatf("a%0d_in_ready", i),  128'(auto_in.a_ready),  128'(vecs[i].e_irdy));
            if (vecs[i].v) begin
                check($sformatf("a%0d_mask", i),   128'(auto_out.a_bits_mask),    128'(vecs[i].e_mask));
                check($sformatf("a%0d_data", i),   128'(auto_out.a_bits_data),    128'(vecs[i].e_data));
                check($sformatf("a%0d_addr", i),   128'(auto_out.a_bits_address), 128'(vecs[i].addr));
                check($sformatf("a%0d_source", i), 128'(auto_out.a_bits_source),  128'(6'(i)));
                check($sformatf("a%0d_size", i),   128'(auto_out.a_bits_size),    128'(vecs[i].sz));
            end
            tick();
        end
        auto_in.a_valid = 1'b0;

        // AccessAckData size 4: two narrow beats with corrupt on beat 0.
        auto_in.d_ready = 1'b1;
        set_d(3'd1, 4'd4, {8{8'h11}}, 1'b0, 1'b1);
        #3;
        check("gath_b0_out_ready", 128'(auto_out.d_ready), 128'(1'b1));
        check("gath_b0_in_valid",  128'(auto_in.d_valid),  128'(1'b0));
        tick();
        set_d(3'd1, 4'd4, {8{8'h22}}, 1'b0, 1'b0);
        #3;
        check("gath_b1_in_valid",  128'(auto_in.d_valid),        128'(1'b1));
        check("gath_b1_data",      128'(auto_in.d_bits_data),    {{8{8'h22}}, {8{8'h11}}});
        check("gath_b1_corrupt",   128'(auto_in.d_bits_corrupt), 128'(1'b1));
        check("gath_b1_denied",    128'(auto_in.d_bits_denied),  128'(1'b0));
        check("gath_b1_opcode",    128'(auto_in.d_bits_opcode),  128'(3'd1));
        check("gath_b1_source",    128'(auto_in.d_bits_source),  128'(6'h2A));
        check("gath_b1_out_ready", 128'(auto_out.d_ready),       128'(1'b1));
        tick();

        // AccessAckData size 2: single beat replicated, zero latency.
        set_d(3'd1, 4'd2, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        #3;
        check("small_in_valid",  128'(auto_in.d_valid),     128'(1'b1));
        check("small_data",      128'(auto_in.d_bits_data), {64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF});
        check("small_out_ready", 128'(auto_out.d_ready),    128'(1'b1));
        tick();

        // Dataless AccessAck size 4: a single beat with data forced to zero.
        set_d(3'd0, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        #3;
        check("ack_in_valid", 128'(auto_in.d_valid),     128'(1'b1));
        check("ack_data",     128'(auto_in.d_bits_data), 128'(0));
        tick();

        // Upstream stall of 3 cycles on the last gathered beat.
        set_d(3'd1, 4'd4, {8{8'h33}}, 1'b0, 1'b0);
        tick();
        set_d(3'd1, 4'd4, {8{8'h44}}, 1'b0, 1'b0);
        auto_in.d_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #3;
            check($sformatf("stall%0d_out_ready", c), 128'(auto_out.d_ready),    128'(1'b0));
            check($sformatf("stall%0d_in_valid", c),  128'(auto_in.d_valid),     128'(1'b1));
            check($sformatf("stall%0d_data", c),      128'(auto_in.d_bits_data), {{8{8'h44}}, {8{8'h33}}});
            tick();
        end
        auto_in.d_ready = 1'b1;
        #3;
        check("stall_release_out_ready", 128'(auto_out.d_ready),    128'(1'b1));
        check("stall_release_data",      128'(auto_in.d_bits_data), {{8{8'h44}}, {8{8'h33}}});
        tick();
        auto_out.d_valid = 1'b0;
        #3;
        check("stall_after_in_valid", 128'(auto_in.d_valid), 128'(1'b0));
        tick();

        // Reset after beat 0 of a gather, then a fresh two-beat response.
        set_d(3'd1, 4'd4, {8{8'h55}}, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        #2;
        check("midrst_out_d_ready", 128'(auto_out.d_ready), 128'(1'b0));
        check("midrst_in_d_valid",  128'(auto_in.d_valid),  128'(1'b0));
        auto_out.d_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        tick();
        set_d(3'd1, 4'd4, {8{8'h66}}, 1'b0, 1'b0);
        #3;
        check("fresh_b0_in_valid", 128'(auto_in.d_valid), 128'(1'b0));
        tick();
        set_d(3'd1, 4'd4, {8{8'h77}}, 1'b0, 1'b0);
        #3;
        check("fresh_b1_in_valid", 128'(auto_in.d_valid),        128'(1'b1));
        check("fresh_b1_data",     128'(auto_in.d_bits_data),    {{8{8'h77}}, {8{8'h66}}});
        check("fresh_b1_corrupt",  128'(auto_in.d_bits_corrupt), 128'(1'b0));
        check("fresh_b1_denied",   128'(auto_in.d_bits_denied),  128'(1'b0));
        tick();
        auto_out.d_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
